// File: rtl/sar_cmp_sequencer.sv
// Successive-approximation sequencer: steps the DAC trial code one bit at a time,
// samples the synchronized comparator decision per bit and reports the final code.
module sar_cmp_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned T_CYC = SETTLE_CYC + SYNC_STAGES;
    localparam int unsigned CNT_W = $clog2(T_CYC + 1);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       dac_q, dac_d;
    logic [WIDTH-1:0]       res_q, res_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;
    logic [WIDTH-1:0]       trial;

    // Comparator output is asynchronous to clk; only the synchronized copy is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
        end
    end

    assign cmp_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dac_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; busy/done are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        trial   = dac_q;

        if (!cmp_s) begin
            trial[idx_q] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    dac_d   = WIDTH'(1) << (WIDTH - 1);
                    idx_d   = IDX_W'(WIDTH - 1);
                    cnt_d   = CNT_W'(T_CYC);
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    dac_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    dac_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (idx_q != '0) begin
                    dac_d              = trial;
                    dac_d[idx_q - IDX_W'(1)] = 1'b1;
                    idx_d              = idx_q - IDX_W'(1);
                    cnt_d              = CNT_W'(T_CYC);
                    state_d            = S_SETTLE;
                end else begin
                    dac_d   = trial;
                    res_d   = trial;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_DECIDE);
        done_d = (state_d == S_DONE);
    end

    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;

endmodule

// File: tb/tb_sar_cmp_sequencer.sv
// Directed bench for sar_cmp_sequencer with default parameters (8 bits, 4-cycle settle).
module tb_sar_cmp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       cmp_in;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int         checks = 0;
    int         errors = 0;
    int         cmp_mode = 0;
    logic [7:0] target = 8'h00;

    sar_cmp_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: tied low, tied high, or an ideal compare against target.
    always_comb begin
        cmp_in = 1'b0;
        case (cmp_mode)
            1:       cmp_in = 1'b1;
            2:       cmp_in = (target >= dac_code);
            default: cmp_in = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that sampled start (edge 0).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int n);
        n = 0;
        while (!done && n < max_edges) begin
            tick();
            n++;
        end
    endtask

    logic [7:0] trials_a5 [8];
    logic [7:0] exp_code;
    int         n;
    int         ndone;
    int         done_edge;

    initial begin
        trials_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #2;
        check("rst_dac", 32'(dac_code), 32'h00);
        check("rst_result", 32'(result), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        #6;
        rst = 1'b0;
        tick();
        tick();

        // Comparator always high: every bit kept, done after 40 edges past start.
        cmp_mode = 1;
        pulse_start();
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_first_trial", 32'(dac_code), 32'h80);
        wait_done(60, n);
        check("t1_latency", 32'(n), 32'd40);
        check("t1_done", 32'(done), 32'h1);
        check("t1_result", 32'(result), 32'hFF);
        check("t1_dac", 32'(dac_code), 32'hFF);
        check("t1_busy_in_done", 32'(busy), 32'h0);
        tick();
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_result_held", 32'(result), 32'hFF);

        // Comparator always low: walking-one trials, final code zero.
        cmp_mode = 0;
        pulse_start();
        for (int j = 0; j < 8; j++) begin
            exp_code = 8'h80 >> j;
            check("t2_trial", 32'(dac_code), 32'(exp_code));
            repeat (5) tick();
        end
        check("t2_done", 32'(done), 32'h1);
        check("t2_result", 32'(result), 32'h00);
        tick();
        check("t2_busy_after", 32'(busy), 32'h0);

        // Ideal comparator against 0xA5.
        cmp_mode = 2;
        target   = 8'hA5;
        pulse_start();
        for (int j = 0; j < 8; j++) begin
            check("t3_trial", 32'(dac_code), 32'(trials_a5[j]));
            repeat (5) tick();
        end
        check("t3_done", 32'(done), 32'h1);
        check("t3_result", 32'(result), 32'hA5);
        tick();

        // start re-pulsed mid-conversion is ignored.
        pulse_start();
        ndone     = 0;
        done_edge = 0;
        for (int e = 1; e <= 45; e++) begin
            start = (e == 5 || e == 20);
            tick();
            if (done) begin
                ndone++;
                done_edge = e;
            end
        end
        start = 1'b0;
        check("t4_done_count", 32'(ndone), 32'd1);
        check("t4_done_edge", 32'(done_edge), 32'd40);
        check("t4_result", 32'(result), 32'hA5);

        // Abort sampled at edge 12: back to idle, no done, result untouched.
        cmp_mode = 1;
        pulse_start();
        repeat (11) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_dac", 32'(dac_code), 32'h00);
        check("t5_done", 32'(done), 32'h0);
        check("t5_result", 32'(result), 32'hA5);
        ndone = 0;
        for (int e = 0; e < 45; e++) begin
            tick();
            if (done) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        check("t5_result_kept", 32'(result), 32'hA5);

        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5b_busy", 32'(busy), 32'h1);
        check("t5b_dac", 32'(dac_code), 32'h80);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5b_abort_busy", 32'(busy), 32'h0);

        // start held through DONE relaunches from IDLE one cycle after done.
        start = 1'b1;
        tick();
        wait_done(60, n);
        check("t5c_latency", 32'(n), 32'd40);
        check("t5c_result", 32'(result), 32'hFF);
        tick();
        check("t5c_idle_busy", 32'(busy), 32'h0);
        check("t5c_idle_done", 32'(done), 32'h0);
        tick();
        check("t5c_relaunch_busy", 32'(busy), 32'h1);
        check("t5c_relaunch_dac", 32'(dac_code), 32'h80);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset between edges mid-SETTLE, then a clean conversion.
        pulse_start();
        repeat (2) tick();
        #3;
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_dac", 32'(dac_code), 32'h00);
        check("t6_done", 32'(done), 32'h0);
        check("t6_result", 32'(result), 32'h00);
        #2;
        rst = 1'b0;
        cmp_mode = 2;
        target   = 8'h5A;
        tick();
        pulse_start();
        wait_done(60, n);
        check("t6_latency", 32'(n), 32'd40);
        check("t6_result_after", 32'(result), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
